// File: rtl/wb_fir_axi_bridge.sv
// rtl/wb_fir_axi_bridge.sv - Wishbone slave turning CPU accesses into FIR AXI-Lite transfers or AXI-Stream beats
module wb_fir_axi_bridge #(
    parameter logic [15:0] FIR_BASE = 16'h3000,
    parameter int          ADDR_W   = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    output logic              ss_tvalid,
    input  logic              ss_tready,
    output logic [31:0]       ss_tdata,
    output logic              ss_tlast,
    input  logic              sm_tvalid,
    output logic              sm_tready,
    input  logic [31:0]       sm_tdata
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LWR  = 3'd1;
    localparam logic [2:0] S_LRD  = 3'd2;
    localparam logic [2:0] S_SWR  = 3'd3;
    localparam logic [2:0] S_SRD  = 3'd4;
    localparam logic [2:0] S_ACK  = 3'd5;

    localparam logic [ADDR_W-1:0] OFF_X      = ADDR_W'(32'h080);
    localparam logic [ADDR_W-1:0] OFF_Y      = ADDR_W'(32'h084);
    localparam logic [ADDR_W-1:0] OFF_X_LAST = ADDR_W'(32'h088);

    logic              wb_act;
    logic              hit;
    logic [ADDR_W-1:0] off;
    logic              unused_ok;

    assign wb_act    = wbs_cyc_i & wbs_stb_i;
    assign hit       = wb_act & (wbs_adr_i[31:16] == FIR_BASE);
    assign off       = wbs_adr_i[ADDR_W-1:0];
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[15:0]};

    logic [2:0]        state_q, state_d;
    logic              abort_q, abort_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              ss_tvalid_q, ss_tvalid_d;
    logic              ss_tlast_q, ss_tlast_d;
    logic              sm_tready_q, sm_tready_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       ss_tdata_q, ss_tdata_d;

    logic        abort_now;
    logic        done;
    logic [31:0] done_dat;
    logic        aw_left;
    logic        w_left;

    always_comb begin
        state_d     = state_q;
        abort_d     = abort_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ss_tvalid_d = ss_tvalid_q;
        ss_tlast_d  = ss_tlast_q;
        sm_tready_d = sm_tready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        ss_tdata_d  = ss_tdata_q;
        ack_d       = 1'b0;
        dat_d       = 32'd0;
        done        = 1'b0;
        done_dat    = 32'd0;
        aw_left     = 1'b0;
        w_left      = 1'b0;
        // A master that drops cyc/stb mid-transfer still lets started AXI handshakes finish.
        abort_now   = abort_q | ~wb_act;
        abort_d     = abort_now;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (hit) begin
                    if (off < OFF_X) begin
                        if (wbs_we_i) begin
                            state_d   = S_LWR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            awaddr_d  = off;
                            wdata_d   = wbs_dat_i;
                        end else begin
                            state_d   = S_LRD;
                            arvalid_d = 1'b1;
                            rready_d  = 1'b1;
                            araddr_d  = off;
                        end
                    end else if (wbs_we_i && (off == OFF_X || off == OFF_X_LAST)) begin
                        state_d     = S_SWR;
                        ss_tvalid_d = 1'b1;
                        ss_tdata_d  = wbs_dat_i;
                        ss_tlast_d  = (off == OFF_X_LAST);
                    end else if (!wbs_we_i && off == OFF_Y) begin
                        state_d     = S_SRD;
                        sm_tready_d = 1'b1;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_LWR: begin
                aw_left   = awvalid_q & ~awready;
                w_left    = wvalid_q & ~wready;
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                done      = ~aw_left & ~w_left;
            end
            S_LRD: begin
                arvalid_d = arvalid_q & ~arready;
                if (rvalid && rready_q) begin
                    rready_d = 1'b0;
                    done     = 1'b1;
                    done_dat = rdata;
                end
            end
            S_SWR: begin
                if (ss_tready) begin
                    ss_tvalid_d = 1'b0;
                    done        = 1'b1;
                end
            end
            S_SRD: begin
                if (sm_tvalid) begin
                    sm_tready_d = 1'b0;
                    done        = 1'b1;
                    done_dat    = sm_tdata;
                end else if (abort_now) begin
                    sm_tready_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            if (abort_now) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_ACK;
                ack_d   = 1'b1;
                dat_d   = done_dat;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            abort_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ss_tvalid_q <= 1'b0;
            ss_tlast_q  <= 1'b0;
            sm_tready_q <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            awaddr_q    <= '0;
            wdata_q     <= 32'd0;
            araddr_q    <= '0;
            ss_tdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ss_tvalid_q <= ss_tvalid_d;
            ss_tlast_q  <= ss_tlast_d;
            sm_tready_q <= sm_tready_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            ss_tdata_q  <= ss_tdata_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign rready    = rready_q;
    assign ss_tvalid = ss_tvalid_q;
    assign ss_tdata  = ss_tdata_q;
    assign ss_tlast  = ss_tlast_q;
    assign sm_tready = sm_tready_q;

endmodule
